// File: rtl/grid_writer.sv
// ============================================================================
// grid_writer : clears the 160x120 occupancy grid, then rasterises object
//               rectangles into it (index 120*x+y). Option: GRID_WRITER_CLIP_EN
// Revision    : 1.0
// ============================================================================
`default_nettype none

module grid_writer #(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              obj_valid,
  output logic              obj_ready,
  input  logic [7:0]        obj_x,
  input  logic [6:0]        obj_y,
  input  logic [3:0]        obj_w,
  input  logic [3:0]        obj_h,
  input  logic              obj_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              obj_dropped
);

  localparam logic [8:0]        c_GRID_W9   = 9'(GRID_W);
  localparam logic [7:0]        c_GRID_H8   = 8'(GRID_H);
  localparam logic [ADDR_W-1:0] c_GRID_HA   = ADDR_W'(GRID_H);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACCEPT = 3'd2,
    S_DRAW   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  logic [8:0]  r_cx;
  logic [7:0]  r_cy;
  logic [7:0]  r_y_first;
  logic [8:0]  r_x_last;
  logic [7:0]  r_y_last;
  logic        r_last;

  logic [8:0]        w_x_end;
  logic [7:0]        w_y_end;
  logic [8:0]        w_x_last;
  logic [7:0]        w_y_last;
  logic              w_empty;
  logic              w_skip;
  logic              w_reject;
  logic [ADDR_W-1:0] w_first_addr;
  logic [ADDR_W-1:0] w_next_col_addr;

  // Exclusive end coordinates are one bit wider than the inputs so they never wrap.
  always_comb begin
    w_x_end = {1'b0, obj_x} + {5'd0, obj_w};
    w_y_end = {1'b0, obj_y} + {4'd0, obj_h};
    w_empty = (obj_w == 4'd0) || (obj_h == 4'd0);
`ifdef GRID_WRITER_CLIP_EN
    w_skip   = w_empty || ({1'b0, obj_x} >= c_GRID_W9) || ({1'b0, obj_y} >= c_GRID_H8);
    w_reject = 1'b0;
    w_x_last = (w_x_end > c_GRID_W9) ? (c_GRID_W9 - 9'd1) : (w_x_end - 9'd1);
    w_y_last = (w_y_end > c_GRID_H8) ? (c_GRID_H8 - 8'd1) : (w_y_end - 8'd1);
`else
    w_skip   = w_empty;
    w_reject = !w_empty && ((w_x_end > c_GRID_W9) || (w_y_end > c_GRID_H8));
    w_x_last = w_x_end - 9'd1;
    w_y_last = w_y_end - 8'd1;
`endif
    w_first_addr    = ADDR_W'({1'b0, obj_x}) * c_GRID_HA + ADDR_W'(obj_y);
    w_next_col_addr = ADDR_W'(r_cx + 9'd1) * c_GRID_HA + ADDR_W'(r_y_first);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cx       <= '0;
      r_cy       <= '0;
      r_y_first  <= '0;
      r_x_last   <= '0;
      r_y_last   <= '0;
      r_last     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 1'b0;
      obj_ready  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifndef GRID_WRITER_CLIP_EN
      obj_dropped <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
`ifndef GRID_WRITER_CLIP_EN
      obj_dropped <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_CLEAR;
            busy      <= 1'b1;
            wr_en     <= 1'b1;
            wr_data   <= 1'b0;
            wr_addr   <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_y_first <= '0;
            r_x_last  <= '0;
            r_y_last  <= '0;
            r_last    <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (wr_addr == c_LAST_ADDR) begin
            wr_en     <= 1'b0;
            obj_ready <= 1'b1;
            r_state   <= S_ACCEPT;
          end else begin
            wr_addr <= wr_addr + 1'b1;
          end
        end
        S_ACCEPT: begin
          if (!obj_ready) begin
            obj_ready <= 1'b1;
          end else if (obj_valid) begin
            obj_ready <= 1'b0;
            r_last    <= obj_last;
            if (w_skip || w_reject) begin
`ifndef GRID_WRITER_CLIP_EN
              obj_dropped <= w_reject;
`endif
              if (obj_last) begin
                r_state    <= S_DONE;
                frame_done <= 1'b1;
              end
            end else begin
              r_state   <= S_DRAW;
              wr_en     <= 1'b1;
              wr_data   <= 1'b1;
              wr_addr   <= w_first_addr;
              r_cx      <= {1'b0, obj_x};
              r_cy      <= {1'b0, obj_y};
              r_y_first <= {1'b0, obj_y};
              r_x_last  <= w_x_last;
              r_y_last  <= w_y_last;
            end
          end
        end
        S_DRAW: begin
          // Column-major scan: y inner, x outer.
          if (r_cy == r_y_last) begin
            if (r_cx == r_x_last) begin
              wr_en   <= 1'b0;
              wr_data <= 1'b0;
              if (r_last) begin
                r_state    <= S_DONE;
                frame_done <= 1'b1;
              end else begin
                r_state   <= S_ACCEPT;
                obj_ready <= 1'b1;
              end
            end else begin
              r_cx    <= r_cx + 9'd1;
              r_cy    <= r_y_first;
              wr_addr <= w_next_col_addr;
            end
          end else begin
            r_cy    <= r_cy + 8'd1;
            wr_addr <= wr_addr + 1'b1;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          wr_en     <= 1'b0;
          obj_ready <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GRID_WRITER_CLIP_EN
  assign obj_dropped = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_grid_writer.sv
// ============================================================================
// tb_grid_writer : directed self-checking bench for grid_writer.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_grid_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        obj_valid = 1'b0;
  logic        obj_last = 1'b0;
  logic [7:0]  obj_x = '0;
  logic [6:0]  obj_y = '0;
  logic [3:0]  obj_w = '0;
  logic [3:0]  obj_h = '0;
  logic        obj_ready;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic        wr_data;
  logic        busy;
  logic        frame_done;
  logic        obj_dropped;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int q_addr[$];
  int q_data[$];
  int exp_q[$];
  int n_done = 0;
  int n_drop = 0;

  grid_writer #(.GRID_W(160), .GRID_H(120), .ADDR_W(15)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .obj_valid  (obj_valid),
    .obj_ready  (obj_ready),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_w      (obj_w),
    .obj_h      (obj_h),
    .obj_last   (obj_last),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .obj_dropped(obj_dropped)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      if (wr_en) begin
        q_addr.push_back(int'(wr_addr));
        q_data.push_back(int'(wr_data));
      end
      if (frame_done) n_done++;
      if (obj_dropped) n_drop++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic send_obj(input string tag, input int x, input int y, input int w,
                          input int h, input bit last);
    int n;
    obj_x     = 8'(x);
    obj_y     = 7'(y);
    obj_w     = 4'(w);
    obj_h     = 4'(h);
    obj_last  = last;
    obj_valid = 1'b1;
    n = 0;
    while (!obj_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_ready"}, obj_ready, 1);
    @(negedge clock);
    obj_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!obj_ready && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_ready_timeout"}, obj_ready, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!frame_done && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_done_timeout"}, frame_done, 1);
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_count"}, q_addr.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < q_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), q_addr[i], exp_q[i]);
        chk($sformatf("%s_data%0d", tag, i), q_data[i], 1);
      end
    end
  endtask

  task automatic check_clear(input string tag);
    int bad_addr = 0;
    int bad_data = 0;
    for (int i = 0; i < q_addr.size(); i++) begin
      if (q_addr[i] != i) bad_addr++;
      if (q_data[i] != 0) bad_data++;
    end
    chk({tag, "_len"}, q_addr.size(), 19200);
    chk({tag, "_order_errs"}, bad_addr, 0);
    chk({tag, "_data_errs"}, bad_data, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_obj_ready", obj_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_obj_dropped", obj_dropped, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy", busy, 0);

    // Frame A: full clear
    clear_log();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("clr_busy", busy, 1);
    chk("clr_first_en", wr_en, 1);
    chk("clr_first_addr", wr_addr, 0);
    chk("clr_first_data", wr_data, 0);
    wait_ready("clear1", 20000);
    check_clear("clear1");
    chk("accept_busy", busy, 1);

    // Single pixel at origin
    clear_log();
    send_obj("o1", 0, 0, 1, 1, 1'b0);
    chk("o1_ready_drop", obj_ready, 0);
    chk("o1_first_en", wr_en, 1);
    chk("o1_first_addr", wr_addr, 0);
    chk("o1_first_data", wr_data, 1);
    wait_ready("o1", 50);
    exp_q = '{0};
    compare_writes("o1");

    // Single pixel at far corner
    clear_log();
    send_obj("o2", 159, 119, 1, 1, 1'b0);
    wait_ready("o2", 50);
    exp_q = '{19199};
    compare_writes("o2");

    // Rectangle straddling both grid edges
    clear_log();
    send_obj("o3", 158, 118, 4, 4, 1'b0);
`ifdef GRID_WRITER_CLIP_EN
    chk("o3_dropped", obj_dropped, 0);
    wait_ready("o3", 50);
    exp_q = '{19078, 19079, 19198, 19199};
    compare_writes("o3");
    chk("o3_drop_count", n_drop, 0);
`else
    chk("o3_dropped", obj_dropped, 1);
    chk("o3_no_write", wr_en, 0);
    wait_ready("o3", 50);
    exp_q.delete();
    compare_writes("o3");
    chk("o3_drop_count", n_drop, 1);
`endif

    // Zero-width, not last: stays in the frame
    clear_log();
    send_obj("o4", 20, 20, 0, 5, 1'b0);
    wait_ready("o4", 50);
    exp_q.delete();
    compare_writes("o4");
    chk("o4_busy", busy, 1);
    chk("o4_no_done", n_done, 0);

    // Last object; start pulsed mid-draw must be ignored
    clear_log();
    send_obj("o5", 10, 5, 2, 3, 1'b1);
    chk("o5_first_addr", wr_addr, 1205);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("o5", 50);
    exp_q = '{1205, 1206, 1207, 1325, 1326, 1327};
    compare_writes("o5");
    @(negedge clock);
    chk("o5_done_count", n_done, 1);
    chk("o5_idle_busy", busy, 0);
    chk("o5_done_pulse", frame_done, 0);
    repeat (3) @(negedge clock);
    chk("o5_start_ignored_busy", busy, 0);
    chk("o5_start_ignored_wr", wr_en, 0);

    // Frame B: reset in the middle of the clear
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    begin
      int n = 0;
      while (wr_addr != 15'd500 && n < 1000) begin
        @(negedge clock);
        n++;
      end
    end
    chk("mid_clr_reached", wr_addr, 500);
    reset = 1'b1;
    #1;
    chk("async_wr_en", wr_en, 0);
    chk("async_wr_addr", wr_addr, 0);
    chk("async_busy", busy, 0);
    chk("async_obj_ready", obj_ready, 0);
    chk("async_frame_done", frame_done, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    clear_log();
    chk("abort_no_done", n_done, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("reclr_first_en", wr_en, 1);
    chk("reclr_first_addr", wr_addr, 0);
    wait_ready("clear2", 20000);
    check_clear("clear2");

    // Zero-width last object closes the frame with no writes
    clear_log();
    send_obj("o6", 3, 3, 0, 5, 1'b1);
    chk("o6_no_write", wr_en, 0);
    wait_done("o6", 10);
    @(negedge clock);
    chk("o6_done_count", n_done, 2);
    chk("o6_writes", q_addr.size(), 0);
    chk("o6_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
